// File: rtl/transport_tx_byte_packer.sv
// Byte FIFO plus LSB-first 64-bit word packer feeding the 64b/66b TX encoder.
// Optional PAD_PARTIAL_EN: pad a stalled partial word with PAD_BYTE after PAD_TIMEOUT idle cycles.
module transport_tx_byte_packer #(
  parameter int          FIFO_DEPTH   = 16,
  parameter logic [2:0]  ACTIVE_PHASE = 3'd4,
  parameter logic [7:0]  PAD_BYTE     = 8'h00,
  parameter int          PAD_TIMEOUT  = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    transport_layer_data_in,
  input  logic                          enable_sending,
  input  logic [2:0]                    phase,
  output logic [63:0]                   word_out,
  output logic                          word_valid,
  input  logic                          word_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] HOLD    = 2'd2;

  logic [1:0]    state;
  logic [2:0]    cnt;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [7:0]    mem [FIFO_DEPTH];
  logic          active, full, push, pop;

  assign active = (phase == ACTIVE_PHASE);
  // Full is judged on the registered level, so a same-cycle pop never frees a slot for a push.
  assign full   = (fifo_level == LW'(FIFO_DEPTH));
  assign push   = enable_sending && active && !full;
  assign pop    = active && (state == COLLECT) && (fifo_level != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= transport_layer_data_in;
  end

`ifdef PAD_PARTIAL_EN
  localparam int IW = $clog2(PAD_TIMEOUT + 1);
  logic [IW-1:0] idle_cnt;
  logic          idle, pad_fire;

  // A partial word is stalled: some lanes filled, nothing buffered, nothing arriving.
  assign idle     = active && (state == COLLECT) && (cnt != 3'd0) &&
                    (fifo_level == '0) && !push;
  assign pad_fire = idle && (idle_cnt == IW'(PAD_TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  idle_cnt <= '0;
    else if (!idle || pad_fire) idle_cnt <= '0;
    else                        idle_cnt <= idle_cnt + 1'b1;
  end
`else
  logic pad_fire;
  logic unused_cfg;
  assign pad_fire   = 1'b0;
  assign unused_cfg = ^{PAD_BYTE, PAD_TIMEOUT[0]};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
      state      <= IDLE;
      cnt        <= 3'd0;
      word_out   <= '0;
      word_valid <= 1'b0;
    end else if (!active) begin
      // Flush outranks push, pop and handshake.
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
      state      <= IDLE;
      cnt        <= 3'd0;
      word_out   <= '0;
      word_valid <= 1'b0;
    end else begin
      if (enable_sending && full) overflow <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase

      case (state)
        IDLE: state <= COLLECT;
        COLLECT: begin
          if (pop) begin
            word_out[8*int'(cnt) +: 8] <= mem[rd_ptr];
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              state      <= HOLD;
              word_valid <= 1'b1;
            end
          end else if (pad_fire) begin
            for (int i = 0; i < 8; i++)
              if (i >= int'(cnt)) word_out[8*i +: 8] <= PAD_BYTE;
            state      <= HOLD;
            word_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (word_ready) begin
            word_valid <= 1'b0;
            cnt        <= 3'd0;
            state      <= COLLECT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_transport_tx_byte_packer.sv
// Directed bench for transport_tx_byte_packer; expected values are hand-computed constants.
module tb_transport_tx_byte_packer;
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  data;
  logic        en;
  logic [2:0]  phase;
  logic [63:0] word_out;
  logic        word_valid;
  logic        word_ready;
  logic [4:0]  fifo_level;
  logic        overflow;

  int n_chk = 0;
  int n_pass = 0;

  transport_tx_byte_packer dut (
    .clk                     (clk),
    .reset                   (reset),
    .transport_layer_data_in (data),
    .enable_sending          (en),
    .phase                   (phase),
    .word_out                (word_out),
    .word_valid              (word_valid),
    .word_ready              (word_ready),
    .fifo_level              (fifo_level),
    .overflow                (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    data = b;
    en   = 1'b1;
    step();
    en   = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int max);
    for (int i = 0; i < max && !word_valid; i++) step();
    chk(tag, {63'd0, word_valid}, 64'd1);
  endtask

  initial begin
    reset = 1'b1; data = 8'h00; en = 1'b0; phase = 3'd0; word_ready = 1'b0;
    step(); step();
    chk("rst_word", word_out, 64'd0);
    chk("rst_valid", {63'd0, word_valid}, 64'd0);
    chk("rst_level", {59'd0, fifo_level}, 64'd0);
    chk("rst_ovf", {63'd0, overflow}, 64'd0);
    reset = 1'b0;
    step();

    // 1: one word, ready held high, exact latency
    phase = 3'd4; word_ready = 1'b1;
    step();
    for (int i = 1; i <= 8; i++) send(8'(i));
    chk("t1_lvl_after8", {59'd0, fifo_level}, 64'd1);
    chk("t1_valid_early", {63'd0, word_valid}, 64'd0);
    step();
    chk("t1_valid", {63'd0, word_valid}, 64'd1);
    chk("t1_word", word_out, 64'h0807060504030201);
    step();
    chk("t1_valid_drop", {63'd0, word_valid}, 64'd0);

    // 2: 16 bytes with encoder stalled
    word_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(8'h10 + 8'(i));
    chk("t2_level", {59'd0, fifo_level}, 64'd8);
    chk("t2_valid", {63'd0, word_valid}, 64'd1);
    chk("t2_word1", word_out, 64'h1716151413121110);
    step(); step(); step();
    chk("t2_word1_stable", word_out, 64'h1716151413121110);
    chk("t2_valid_stable", {63'd0, word_valid}, 64'd1);
    word_ready = 1'b1;
    step();
    chk("t2_hs_drop", {63'd0, word_valid}, 64'd0);
    wait_valid("t2_to_word2", 20);
    chk("t2_word2", word_out, 64'h1F1E1D1C1B1A1918);

    // 3: overflow with encoder stalled
    word_ready = 1'b0;
    phase = 3'd1; step();
    phase = 3'd4; step();
    for (int i = 1; i <= 24; i++) send(8'h30 + 8'(i));
    chk("t3_lvl_full", {59'd0, fifo_level}, 64'd16);
    chk("t3_ovf_before", {63'd0, overflow}, 64'd0);
    send(8'h30 + 8'd25);
    chk("t3_ovf_after25", {63'd0, overflow}, 64'd1);
    for (int i = 26; i <= 30; i++) send(8'h30 + 8'(i));
    chk("t3_lvl_end", {59'd0, fifo_level}, 64'd16);
    chk("t3_word1", word_out, 64'h3837363534333231);
    word_ready = 1'b1;
    step();
    wait_valid("t3_to_word2", 20);
    chk("t3_word2", word_out, 64'h403F3E3D3C3B3A39);
    chk("t3_ovf_sticky", {63'd0, overflow}, 64'd1);

    // 4: flush while a word is held, ignored bytes, flush of a partial word
    word_ready = 1'b0;
    phase = 3'd1; step();
    chk("t4_valid", {63'd0, word_valid}, 64'd0);
    chk("t4_level", {59'd0, fifo_level}, 64'd0);
    chk("t4_ovf", {63'd0, overflow}, 64'd0);
    send(8'hEE);
    chk("t4_ign_level", {59'd0, fifo_level}, 64'd0);
    chk("t4_ign_ovf", {63'd0, overflow}, 64'd0);
    phase = 3'd4; step();
    for (int i = 1; i <= 5; i++) send(8'hA0 + 8'(i));
    phase = 3'd1; step();
    chk("t4_pflush_level", {59'd0, fifo_level}, 64'd0);
    chk("t4_pflush_valid", {63'd0, word_valid}, 64'd0);
    phase = 3'd4; step();
    word_ready = 1'b1;
    for (int i = 1; i <= 8; i++) send(8'hB0 + 8'(i));
    wait_valid("t4_to_word", 20);
    chk("t4_word", word_out, 64'hB8B7B6B5B4B3B2B1);
    step();

    // 5: async reset during HOLD
    word_ready = 1'b0;
    for (int i = 1; i <= 8; i++) send(8'hC0 + 8'(i));
    wait_valid("t5_to_word", 20);
    #2 reset = 1'b1;
    #1;
    chk("t5_valid", {63'd0, word_valid}, 64'd0);
    chk("t5_level", {59'd0, fifo_level}, 64'd0);
    chk("t5_word", word_out, 64'd0);
    step();
    reset = 1'b0;
    step();

    // 6: partial word followed by silence
    send(8'hAA); send(8'hBB); send(8'hCC);
    step(); step(); step(); step();
    chk("t6_no_early", {63'd0, word_valid}, 64'd0);
`ifdef PAD_PARTIAL_EN
    wait_valid("t6_to_pad", 30);
    chk("t6_pad_word", word_out, 64'h0000_0000_00CC_BBAA);
`else
    repeat (20) step();
    chk("t6_no_word", {63'd0, word_valid}, 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
